// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B using one full-subtractor cell and a registered borrow, LSB first.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             borrow, x, y, d, bout, accept, last;
    logic [WIDTH:0]   sh;

    always_comb begin
        x        = a_sr[0];
        y        = b_sr[0];
        d        = x ^ y ^ borrow;
        bout     = (~x & y) | (~(x ^ y) & borrow);
        sh       = {d, diff};
        last     = cnt == CW'(WIDTH - 1);
        accept   = start && state != RUN;
        state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // New bits enter diff at the MSB so the first computed bit ends up at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sr       <= a;
            b_sr       <= b;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= bout;
            cnt    <= cnt + CW'(1);
            diff   <= sh[WIDTH:1];
            if (last) borrow_out <= bout;
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and random checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s8 = 1'b0, s1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       busy8, done8, bo8, busy1, done1, bo1;
    int         total = 0, pass = 0, acc8 = 0, dn8 = 0, acc1 = 0, dn1 = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t tv[4];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && done8) begin
            dn8++;
            if (q8.size() == 0) check("done8_spurious", 32'(q8.size()), 1);
            else check("result8", {bo8, diff8}, q8.pop_front());
        end
        if (!rst && done1) begin
            dn1++;
            if (q1.size() == 0) check("done1_spurious", 32'(q1.size()), 1);
            else check("result1", {bo1, diff1}, q1.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                         input logic eb, input bit hold);
        a8 = a;
        b8 = b;
        s8 = 1'b1;
        q8.push_back({eb, ed});
        acc8++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hold) begin
                s8 = ~i[0];
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else s8 = 1'b0;
            check("busy8", busy8, 1);
            check("done8_early", done8, 0);
        end
        @(negedge clk);
        s8 = 1'b0;
        check("done8", done8, 1);
        check("busy8_in_done", busy8, 0);
    endtask

    task automatic do_op1(input logic a, input logic b);
        logic [1:0] r;
        r  = {1'b0, a} - {1'b0, b};
        a1 = a;
        b1 = b;
        s1 = 1'b1;
        q1.push_back(r);
        acc1++;
        @(negedge clk);
        s1 = 1'b0;
        check("busy1", busy1, 1);
        check("done1_early", done1, 0);
        @(negedge clk);
        check("done1", done1, 1);
        check("busy1_in_done", busy1, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] r;
        int gap;
        tv[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        tv[1] = '{8'h23, 8'h5A, 8'hC9, 1'b1};
        tv[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tv[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", diff8, 0);
        check("rst_bo8", bo8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_out1", {done1, diff1, bo1}, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_op(tv[i].a, tv[i].b, tv[i].d, tv[i].bo, 0);
            @(negedge clk);
            check("idle_done8", done8, 0);
            check("held_diff8", diff8, tv[i].d);
            check("held_bo8", bo8, tv[i].bo);
        end
        // start held and re-pulsed mid-run must not restart the operation
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1);
        @(negedge clk);
        check("no_restart_busy8", busy8, 0);
        check("no_restart_done8", done8, 0);
        check("hold_diff8", diff8, 8'h0F);
        // back-to-back: second start issued during the DONE cycle
        do_op(8'h5A, 8'h23, 8'h37, 1'b0, 0);
        do_op(8'hFF, 8'h0F, 8'hF0, 1'b0, 0);
        @(negedge clk);
        check("b2b_idle", {busy8, done8}, 0);
        // asynchronous reset four cycles into RUN
        a8 = 8'h5A;
        b8 = 8'h23;
        s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy8", busy8, 0);
        check("async_rst_done8", done8, 0);
        check("async_rst_diff8", diff8, 0);
        check("async_rst_bo8", bo8, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {busy8, done8}, 0);
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 0);
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            r   = {1'b0, ra} - {1'b0, rb};
            do_op(ra, rb, r[7:0], r[8], 0);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            do_op1(1'($urandom), 1'($urandom));
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("starts_vs_dones8", dn8, acc8);
        check("starts_vs_dones1", dn1, acc1);
        check("queue8_empty", 32'(q8.size()), 0);
        check("queue1_empty", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
